debug_uart_tx: RTL and testbench
================================

DEBUG_UART_TX -- requirements
Module: debug_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter SYNC_BYTE, default 8'hA5, first byte of every frame.
REQ-003 SHALL use one clock and a synchronous, active-low reset, with ports named clk and nreset.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 nreset  input  1  synchronous active-low reset.
REQ-006 start  input  1  snapshot-and-send request, sampled each rising edge.
REQ-007 debug_port1..debug_port7  input  8 each  CPU debug bytes to transmit.
REQ-008 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame is in progress.
REQ-010 done  output  1  one-cycle pulse at the end of a frame.

Function
REQ-011 SHALL transmit frames of 9 bytes in this order: SYNC_BYTE, debug_port1 through debug_port7, then a checksum byte.
REQ-012 The checksum byte SHALL be the XOR of the seven captured port bytes.
REQ-013 Each byte SHALL be sent as 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit exactly CLKS_PER_BIT cycles; a frame is 90*CLKS_PER_BIT cycles.
REQ-014 The top-level FSM SHALL have states IDLE, START, DATA and STOP, with a byte index of 0..8 and a bit index of 0..7.
REQ-015 In IDLE, when start=1 is seen on an edge, that same edge SHALL capture all seven ports into internal registers, set busy=1 and tx=0 (registered), and enter START.
REQ-016 START, DATA and STOP SHALL each advance after CLKS_PER_BIT cycles; DATA SHALL loop through 8 bits, then go to STOP.
REQ-017 When STOP ends with byte index < 8, the FSM SHALL increment the index and enter START with no idle gap.
REQ-018 When STOP ends with byte index = 8, the FSM SHALL return to IDLE, with busy=0 and done=1 for exactly one cycle on the same edge.
REQ-019 start SHALL be ignored while busy=1; it is not queued, and the captured bytes stay frozen.
REQ-020 If start=1 on the same edge busy falls, it SHALL be ignored; a new frame needs start=1 while in IDLE, so there is at least one idle cycle between frames.
REQ-021 tx, busy and done SHALL be driven directly from flops, with no combinational path from any input to any output.
REQ-022 The baud counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 on every bit boundary; no drift is permitted.

Reset
REQ-023 When nreset=0 on an edge, the block SHALL set tx=1, busy=0, done=0, state=IDLE, all counters=0 and the captured bytes=0.
REQ-024 A reset during a frame SHALL abort it: tx SHALL return high on that edge, no done pulse is issued, and the frame is not resumed.
REQ-025 Reset SHALL take priority over start on the same edge.

Structure
REQ-026 The shared package debug_pkg SHALL hold the FSM state enum, FRAME_BYTES=9, the SYNC_BYTE default and the default CLKS_PER_BIT.
REQ-027 The block SHALL be split into one sub-module, uart_tx_byte, a single-byte 8N1 serializer with a load/busy/done handshake; debug_uart_tx handles sequencing, capture and the checksum.

Verification (CLKS_PER_BIT=4)
REQ-028 Reset, then hold idle: tx=1, busy=0 and done=0 for 20 cycles.
REQ-029 Ports 01,02,03,04,05,06,FF, pulse start: the bench SHALL decode bytes A5,01,02,03,04,05,06,FF,F8; busy high for 360 cycles; done pulse on cycle 360.
REQ-030 Change the ports and re-pulse start at cycle 100 of a frame: the decoded bytes are unchanged and exactly one frame is sent.
REQ-031 Assert nreset=0 at cycle 150 mid-frame: on the next edge tx=1, busy=0 and no done pulse; start afterwards sends a complete fresh frame.
REQ-032 Hold start=1 continuously: frames are sent back-to-back with exactly 1 idle cycle (tx=1) between them, and done pulses once per frame.
REQ-033 Sample every bit's width: each bit is exactly 4 cycles wide with no cumulative drift across all 90 bits.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and defaults for the debug UART frame transmitter.
package debug_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_e;

   localparam int         FRAME_BYTES      = 9;
   localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
   localparam int         DEF_CLKS_PER_BIT = 434;

   function automatic logic [7:0] xor_bytes(input logic [6:0][7:0] b);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < 7; i++) begin
         acc = acc ^ b[i];
      end
      return acc;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Single-byte 8N1 serializer; done_o marks the last stop-bit cycle so a
// new load on that cycle chains the next byte without an idle gap.
module uart_tx_byte
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic          bit_end;

   assign bit_end = (cnt_q == LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (load_i) begin
               state_d = START;
               shift_d = data_i;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[1];
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               if (load_i) begin
                  state_d = START;
                  shift_d = data_i;
                  bit_d   = '0;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == STOP) && bit_end;

endmodule

// File: rtl/debug_uart_tx.sv
// Debug frame sender: sync byte, seven captured port bytes, XOR checksum.
module debug_uart_tx
   import debug_pkg::*;
#(
   parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       start,
   input  logic [7:0] debug_port1,
   input  logic [7:0] debug_port2,
   input  logic [7:0] debug_port3,
   input  logic [7:0] debug_port4,
   input  logic [7:0] debug_port5,
   input  logic [7:0] debug_port6,
   input  logic [7:0] debug_port7,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam logic [3:0] LAST_BYTE = 4'(FRAME_BYTES - 1);

   logic [3:0]      byte_q, byte_d;
   logic [6:0][7:0] port_q, port_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            ser_load;
   logic [7:0]      ser_data;
   logic            ser_tx;
   logic            ser_busy;
   logic            ser_done;
   logic [7:0][7:0] tail;

   // Bytes 1..8 of the frame; slot k feeds byte k+1 when byte k ends.
   assign tail = {xor_bytes(port_q), port_q};

   always_comb begin
      byte_d   = byte_q;
      port_d   = port_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      ser_load = 1'b0;
      ser_data = SYNC_BYTE;
      if (!busy_q) begin
         if (start && !ser_busy) begin
            ser_load = 1'b1;
            busy_d   = 1'b1;
            byte_d   = '0;
            port_d   = {debug_port7, debug_port6, debug_port5,
                        debug_port4, debug_port3, debug_port2,
                        debug_port1};
         end
      end else if (ser_done) begin
         if (byte_q == LAST_BYTE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            byte_d = '0;
         end else begin
            ser_load = 1'b1;
            ser_data = tail[byte_q[2:0]];
            byte_d   = byte_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         byte_q <= '0;
         port_q <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         byte_q <= byte_d;
         port_q <= port_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ser (
      .clk   (clk),
      .nreset(nreset),
      .load_i(ser_load),
      .data_i(ser_data),
      .tx_o  (ser_tx),
      .busy_o(ser_busy),
      .done_o(ser_done)
   );

   assign tx   = ser_tx;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_debug_uart_tx.sv
// Scoreboard bench: pushes expected frame bytes, decodes tx and compares.
module tb_debug_uart_tx;

   localparam int CPB = 4;
   localparam int FLEN = 90 * CPB;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] dp [7];
   logic       tx, busy, done;

   int         vecs = 0;
   int         errs = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   debug_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5)
   ) dut (
      .clk        (clk),
      .nreset     (nreset),
      .start      (start),
      .debug_port1(dp[0]),
      .debug_port2(dp[1]),
      .debug_port3(dp[2]),
      .debug_port4(dp[3]),
      .debug_port5(dp[4]),
      .debug_port6(dp[5]),
      .debug_port7(dp[6]),
      .tx         (tx),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vecs++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   int         cyc = 0;
   int         dcyc = 0;
   int         dbyte = 0;
   int         fstart = 0;
   logic       dact = 1'b0;
   logic       dbad = 1'b0;
   logic [9:0] dbits = '0;
   logic [31:0] dexp;

   // Line decoder: anchors on each start bit, every cycle of a bit must match.
   always @(negedge clk) begin
      cyc++;
      if (!nreset) begin
         dact  = 1'b0;
         dbyte = 0;
      end else if (!dact) begin
         if (tx === 1'b0) begin
            dact  = 1'b1;
            dcyc  = 1;
            dbits = '0;
            dbad  = 1'b0;
            if (dbyte == 0) fstart = cyc;
            chk("drift", cyc - fstart, dbyte * 10 * CPB);
         end
      end else begin
         if (dcyc % CPB == 0) dbits[dcyc / CPB] = tx;
         else if (tx !== dbits[dcyc / CPB]) dbad = 1'b1;
         dcyc++;
         if (dcyc == 10 * CPB) begin
            dact = 1'b0;
            dexp = (sb.size() > 0) ? {24'h0, sb.pop_front()} : 32'h100;
            chk("byte", {24'h0, dbits[8:1]}, dexp);
            chk("stop", {31'h0, dbits[9]}, 32'd1);
            chk("bitw", {31'h0, dbad}, 32'd0);
            dbyte = (dbyte == 8) ? 0 : dbyte + 1;
         end
      end
   end

   task automatic set_ports(input logic [55:0] v);
      for (int i = 0; i < 7; i++) dp[i] = v[8*i +: 8];
   endtask

   task automatic push_frame();
      logic [7:0] cs;
      cs = 8'h00;
      sb.push_back(8'hA5);
      for (int i = 0; i < 7; i++) begin
         sb.push_back(dp[i]);
         cs = cs ^ dp[i];
      end
      sb.push_back(cs);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_frame(input int already);
      int n;
      n = already;
      repeat (3 * FLEN) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      chk("frame_len", n, FLEN);
      chk("done_pulse", {31'h0, done}, 32'd1);
      chk("gap_tx", {31'h0, tx}, 32'd1);
      chk("sb_empty", sb.size(), 0);
   endtask

   task automatic idle_checks(input string tag, input int n);
      repeat (n) begin
         @(negedge clk);
         chk({tag, "_tx"}, {31'h0, tx}, 32'd1);
         chk({tag, "_busy"}, {31'h0, busy}, 32'd0);
         chk({tag, "_done"}, {31'h0, done}, 32'd0);
      end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      set_ports('0);
      nreset = 1'b0;
      repeat (3) @(posedge clk);
      #1 nreset = 1'b1;
      idle_checks("rst", 20);

      set_ports(56'hFF_06_05_04_03_02_01);
      push_frame();
      pulse_start();
      wait_frame(0);
      idle_checks("post1", 2);

      set_ports(56'h77_66_55_44_33_22_11);
      push_frame();
      pulse_start();
      repeat (99) @(posedge clk);
      #1;
      set_ports(56'hDE_AD_BE_EF_12_34_56);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_frame(100);
      idle_checks("norefire", 20);

      set_ports(56'h80_40_20_10_08_04_02);
      push_frame();
      pulse_start();
      repeat (149) @(posedge clk);
      #1 nreset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_tx", {31'h0, tx}, 32'd1);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      @(posedge clk);
      #1 nreset = 1'b1;
      sb.delete();
      idle_checks("postrst", 10);
      set_ports(56'h3C_5A_C3_A5_0F_F0_99);
      push_frame();
      pulse_start();
      wait_frame(0);
      idle_checks("post3", 2);

      set_ports(56'h01_23_45_67_89_AB_CD);
      push_frame();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1;
      wait_frame(0);
      push_frame();
      @(negedge clk);
      chk("b2b_busy", {31'h0, busy}, 32'd1);
      chk("b2b_tx", {31'h0, tx}, 32'd0);
      chk("b2b_done", {31'h0, done}, 32'd0);
      start = 1'b0;
      wait_frame(1);
      idle_checks("end", 5);

      chk("sb_final", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
